// File: rtl/mul_issue_ctrl.sv
// Issue/writeback sequencer for a fixed-latency multiplier: holds operands while the
// multiplier runs, stalls the upstream pipe and strobes the result. Optional flush via `MUL_FLUSH_EN.
module mul_issue_ctrl #(
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [2:0]  issue_funct3,
  input  logic [31:0] issue_rs1,
  input  logic [31:0] issue_rs2,
  input  logic [4:0]  issue_rd,
`ifdef MUL_FLUSH_EN
  input  logic        flush,
`endif
  output logic        mul_ce,
  output logic [2:0]  mul_funct3,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_result,
  output logic        stall_pipe,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam logic [2:0] LAT_CNT = 3'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [2:0]  hold_funct3_q;
  logic [31:0] hold_rs1_q;
  logic [31:0] hold_rs2_q;
  logic [4:0]  hold_rd_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;

  logic flush_w;
  logic accept_d;

`ifdef MUL_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // A new operation may start from IDLE, or from DONE to overlap the writeback cycle.
  // Flush only vetoes an issue in IDLE; in DONE it is ignored entirely.
  always_comb begin
    accept_d = 1'b0;
    if (issue_valid && !issue_funct3[2]) begin
      if (state_q == S_IDLE)
        accept_d = !flush_w;
      else if (state_q == S_DONE)
        accept_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 3'd0;
      hold_funct3_q <= 3'd0;
      hold_rs1_q    <= 32'd0;
      hold_rs2_q    <= 32'd0;
      hold_rd_q     <= 5'd0;
      wb_rd_q       <= 5'd0;
      wb_data_q     <= 32'd0;
    end else if (accept_d) begin
      hold_funct3_q <= issue_funct3;
      hold_rs1_q    <= issue_rs1;
      hold_rs2_q    <= issue_rs2;
      hold_rd_q     <= issue_rd;
      cnt_q         <= LAT_CNT;
      state_q       <= S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          if (flush_w) begin
            cnt_q   <= 3'd0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
              wb_data_q <= mul_result;
              wb_rd_q   <= hold_rd_q;
              state_q   <= S_DONE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_IDLE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mul_ce     = (state_q == S_RUN);
  assign busy       = (state_q == S_RUN);
  assign wb_valid   = (state_q == S_DONE);
  assign stall_pipe = accept_d || (state_q == S_RUN);
  assign mul_funct3 = hold_funct3_q;
  assign mul_a      = hold_rs1_q;
  assign mul_b      = hold_rs2_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: directed scenarios plus a randomized run
// against a cycle-window reference model; a stand-in LATENCY-stage multiplier feeds mul_result.
module tb_mul_issue_ctrl;
  localparam int LAT  = 3;
  localparam int PIDX = (LAT >= 2) ? LAT - 2 : 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [2:0]  issue_funct3;
  logic [31:0] issue_rs1, issue_rs2;
  logic [4:0]  issue_rd;
`ifdef MUL_FLUSH_EN
  logic        flush;
`endif
  logic        mul_ce, stall_pipe, busy, wb_valid;
  logic [2:0]  mul_funct3;
  logic [31:0] mul_a, mul_b, mul_result, wb_data;
  logic [4:0]  wb_rd;

  int checks = 0;
  int errors = 0;

  mul_issue_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_funct3(issue_funct3),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
`ifdef MUL_FLUSH_EN
    .flush(flush),
`endif
    .mul_ce(mul_ce), .mul_funct3(mul_funct3), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .stall_pipe(stall_pipe), .busy(busy),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // Stand-in multiplier: MULH/MULHSU return the high half, every other funct3 the low product.
  function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (f)
      3'b001:  p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      3'b010:  p = {{32{a[31]}}, a} * {32'd0, b};
      default: p = {32'd0, a} * {32'd0, b};
    endcase
    return (f == 3'b001 || f == 3'b010) ? p[63:32] : p[31:0];
  endfunction

  logic [31:0] pipe [0:6];
  always @(posedge clk) begin
    if (mul_ce) begin
      pipe[0] <= ref_mul(mul_funct3, mul_a, mul_b);
      for (int i = 1; i < 7; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mul_result = (LAT == 1) ? ref_mul(mul_funct3, mul_a, mul_b) : pipe[PIDX];

  task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d);
    issue_valid = v; issue_funct3 = f; issue_rs1 = a; issue_rs2 = b; issue_rd = d;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
`ifdef MUL_FLUSH_EN
    flush = 1'b0;
`endif
    drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    repeat (2) advance();
    settle();
    checks++;
    if ({mul_ce, stall_pipe, busy, wb_valid, mul_funct3, wb_rd} !== 12'd0) begin
      errors++;
      $display("FAIL reset_ctrl got ce=%b stall=%b busy=%b wbv=%b f3=%h rd=%h exp all 0",
               mul_ce, stall_pipe, busy, wb_valid, mul_funct3, wb_rd);
    end
    checks++;
    if ({mul_a, mul_b, wb_data} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data got a=%h b=%h wbd=%h exp 0", mul_a, mul_b, wb_data);
    end
    advance();
    reset = 1'b0;
    advance();
  endtask

  task automatic test_basic();
    logic e_stall, e_ce, e_wb;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) drive(1'b1, 3'b000, 32'd7, 32'd6, 5'd5);
      else        drive(1'b0, 3'b000, $urandom, $urandom, 5'($urandom));
      settle();
      e_stall = (c <= 3); e_ce = (c >= 1 && c <= 3); e_wb = (c == 4);
      checks++;
      if (stall_pipe !== e_stall || mul_ce !== e_ce || busy !== e_ce) begin
        errors++;
        $display("FAIL basic_ctrl c=%0d got stall=%b ce=%b busy=%b exp %b %b %b",
                 c, stall_pipe, mul_ce, busy, e_stall, e_ce, e_ce);
      end
      checks++;
      if (wb_valid !== e_wb) begin
        errors++; $display("FAIL basic_wbv c=%0d got %b exp %b", c, wb_valid, e_wb);
      end
      if (c == 4) begin
        checks++;
        if (wb_rd !== 5'd5 || wb_data !== 32'd42) begin
          errors++; $display("FAIL basic_wb got rd=%0d data=%0d exp rd=5 data=42", wb_rd, wb_data);
        end
      end
      advance();
    end
  endtask

  task automatic test_mulh_hold();
    for (int c = 0; c < 6; c++) begin
      if (c == 0)      drive(1'b1, 3'b001, 32'hFFFF_FFFF, 32'd2, 5'd1);
      else if (c <= 3) drive(1'b1, 3'b000, c[0] ? 32'h0 : 32'h1234_5678, 32'd3, 5'd2);
      else             drive(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      settle();
      checks++;
      if (stall_pipe !== (c <= 3)) begin
        errors++; $display("FAIL mulh_stall c=%0d got %b", c, stall_pipe);
      end
      if (c >= 1 && c <= 3) begin
        checks++;
        if (mul_a !== 32'hFFFF_FFFF || mul_b !== 32'd2 || mul_funct3 !== 3'b001) begin
          errors++;
          $display("FAIL mulh_hold c=%0d got a=%h b=%h f3=%b exp ffffffff 2 001", c, mul_a, mul_b, mul_funct3);
        end
      end
      if (c == 4) begin
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'hFFFF_FFFF || wb_rd !== 5'd1) begin
          errors++;
          $display("FAIL mulh_wb got v=%b data=%h rd=%0d exp 1 ffffffff 1", wb_valid, wb_data, wb_rd);
        end
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic e_stall, e_ce, e_wb;
    for (int c = 0; c < 10; c++) begin
      if (c == 0)      drive(1'b1, 3'b000, 32'd7, 32'd6, 5'd5);
      else if (c == 4) drive(1'b1, 3'b011, 32'd3, 32'd4, 5'd9);
      else             drive(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      settle();
      e_stall = (c <= 7);
      e_ce    = (c >= 1 && c <= 3) || (c >= 5 && c <= 7);
      e_wb    = (c == 4) || (c == 8);
      checks++;
      if (stall_pipe !== e_stall || mul_ce !== e_ce || wb_valid !== e_wb) begin
        errors++;
        $display("FAIL b2b_ctrl c=%0d got stall=%b ce=%b wbv=%b exp %b %b %b",
                 c, stall_pipe, mul_ce, wb_valid, e_stall, e_ce, e_wb);
      end
      if (c == 4 || c == 8) begin
        checks++;
        if (wb_data !== ((c == 4) ? 32'd42 : 32'd12) || wb_rd !== ((c == 4) ? 5'd5 : 5'd9)) begin
          errors++; $display("FAIL b2b_wb c=%0d got data=%0d rd=%0d", c, wb_data, wb_rd);
        end
      end
      advance();
    end
  endtask

  task automatic test_rd_zero();
    for (int c = 0; c < 6; c++) begin
      if (c == 0) drive(1'b1, 3'b000, 32'd5, 32'd5, 5'd0);
      else        drive(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      settle();
      if (c == 4) begin
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd0 || wb_data !== 32'd25) begin
          errors++;
          $display("FAIL rd0_wb got v=%b rd=%0d data=%0d exp 1 0 25", wb_valid, wb_rd, wb_data);
        end
      end
      advance();
    end
  endtask

  task automatic test_div_ignored();
    for (int c = 0; c < 7; c++) begin
      drive(c < 3, 3'b100 | 3'($urandom_range(0, 3)), 32'd9, 32'd9, 5'd3);
      settle();
      checks++;
      if ({stall_pipe, mul_ce, busy, wb_valid} !== 4'd0) begin
        errors++;
        $display("FAIL div_ignored c=%0d got stall=%b ce=%b busy=%b wbv=%b exp 0",
                 c, stall_pipe, mul_ce, busy, wb_valid);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_run();
    drive(1'b1, 3'b000, 32'd7, 32'd6, 5'd5);
    advance();
    drive(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    advance();
    reset = 1'b1;
    #1;
    checks++;
    if ({mul_ce, stall_pipe, busy, wb_valid, mul_funct3, wb_rd} !== 12'd0 ||
        {mul_a, mul_b, wb_data} !== 96'd0) begin
      errors++;
      $display("FAIL reset_mid ce=%b stall=%b busy=%b wbv=%b a=%h b=%h wbd=%h exp all 0",
               mul_ce, stall_pipe, busy, wb_valid, mul_a, mul_b, wb_data);
    end
    advance();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      settle();
      checks++;
      if (wb_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_mid_after c=%0d got wbv=%b busy=%b exp 0 0", c, wb_valid, busy);
      end
      advance();
    end
  endtask

`ifdef MUL_FLUSH_EN
  task automatic test_flush();
    logic e_busy, e_wb;
    for (int c = 0; c < 12; c++) begin
      flush = (c == 1);
      if (c == 0)      drive(1'b1, 3'b000, 32'd7, 32'd6, 5'd5);
      else if (c == 7) drive(1'b1, 3'b000, 32'd2, 32'd9, 5'd4);
      else             drive(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      settle();
      e_busy = (c == 1) || (c >= 8 && c <= 10);
      e_wb   = (c == 11);
      checks++;
      if (busy !== e_busy || mul_ce !== e_busy || wb_valid !== e_wb) begin
        errors++;
        $display("FAIL flush_ctrl c=%0d got busy=%b ce=%b wbv=%b exp %b %b %b",
                 c, busy, mul_ce, wb_valid, e_busy, e_busy, e_wb);
      end
      if (c == 11) begin
        checks++;
        if (wb_data !== 32'd18 || wb_rd !== 5'd4) begin
          errors++; $display("FAIL flush_wb got data=%0d rd=%0d exp 18 4", wb_data, wb_rd);
        end
      end
      advance();
    end
    flush = 1'b1;
    drive(1'b1, 3'b000, 32'd1, 32'd1, 5'd1);
    settle();
    checks++;
    if (stall_pipe !== 1'b0) begin
      errors++; $display("FAIL flush_idle_stall got %b exp 0", stall_pipe);
    end
    advance();
    flush = 1'b0;
    drive(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    settle();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_idle_busy got %b exp 0", busy);
    end
    advance();
  endtask
`endif

  // Reference: an accepted issue in cycle t owns RUN cycles t+1..t+LAT and the writeback in t+LAT+1.
  task automatic test_random();
    int          acc_c;
    bit          pend, in_run, in_done, acc, fl;
    logic        v;
    logic [2:0]  f;
    logic [31:0] a, b, m_a, m_b, m_data;
    logic [2:0]  m_f3;
    logic [4:0]  d, m_rd;
    pend = 0; acc_c = -100; m_a = 0; m_b = 0; m_data = 0; m_f3 = 0; m_rd = 0;
    reset = 1'b1;
    advance();
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      v = 1'($urandom_range(0, 1));
      f = 3'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      d = 5'($urandom);
      fl = 0;
`ifdef MUL_FLUSH_EN
      fl = ($urandom_range(0, 11) == 0);
      flush = fl;
`endif
      drive(v, f, a, b, d);
      in_run  = pend && (c > acc_c) && (c <= acc_c + LAT);
      in_done = pend && (c == acc_c + LAT + 1);
      acc     = v && !f[2] && !in_run && !(fl && !in_done);
      settle();
      checks++;
      if (stall_pipe !== (acc || in_run) || mul_ce !== in_run || busy !== in_run || wb_valid !== in_done) begin
        errors++;
        $display("FAIL rand_ctrl c=%0d got stall=%b ce=%b busy=%b wbv=%b exp %b %b %b %b",
                 c, stall_pipe, mul_ce, busy, wb_valid, acc || in_run, in_run, in_run, in_done);
      end
      if (in_run) begin
        checks++;
        if (mul_a !== m_a || mul_b !== m_b || mul_funct3 !== m_f3) begin
          errors++;
          $display("FAIL rand_hold c=%0d got a=%h b=%h f3=%b exp %h %h %b", c, mul_a, mul_b, mul_funct3, m_a, m_b, m_f3);
        end
      end
      if (in_done) begin
        checks++;
        if (wb_data !== m_data || wb_rd !== m_rd) begin
          errors++;
          $display("FAIL rand_wb c=%0d got data=%h rd=%0d exp %h %0d", c, wb_data, wb_rd, m_data, m_rd);
        end
      end
      if (in_run && fl) pend = 0;
      if (in_done) pend = 0;
      if (acc) begin
        pend = 1; acc_c = c;
        m_a = a; m_b = b; m_f3 = f; m_rd = d; m_data = ref_mul(f, a, b);
      end
      advance();
    end
`ifdef MUL_FLUSH_EN
    flush = 1'b0;
`endif
    drive(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    repeat (LAT + 2) advance();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mulh_hold();
    test_back_to_back();
    test_rd_zero();
    test_div_ignored();
    test_reset_mid_run();
`ifdef MUL_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
